// File: rtl/eth_test_pkg.sv
// Shared definitions for the delay-test frame generator.
// - Header byte offsets and the legal frame-length range (bytes, FCS excluded).
// - FSM state encoding.
// - byte_at(): the frame byte at a given index.
//   The 14-byte DA/SA/ethertype header is passed in, so MAC and ethertype
//   overrides on the top module take effect.
package eth_test_pkg;

  localparam int OFS_SEQ = 14;
  localparam int OFS_TS  = 18;
  localparam int OFS_PAD = 26;

  localparam int DEF_MIN_LEN = 60;
  localparam int DEF_MAX_LEN = 1514;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_GAP} state_t;

  // Header fields go out MSB first; the sequence number and the timestamp are
  // big-endian; the padding repeats the low byte of the index.
  function automatic logic [7:0] byte_at(input logic [10:0]  idx,
                                         input logic [31:0]  seq,
                                         input logic [63:0]  ts,
                                         input logic [111:0] hdr);
    int             i;
    logic [111:0]   h;
    logic [31:0]    s;
    logic [63:0]    t;
    i = int'(idx);
    if (i < OFS_SEQ) begin
      h = hdr >> (8 * (OFS_SEQ - 1 - i));
      return h[7:0];
    end else if (i < OFS_TS) begin
      s = seq >> (8 * (OFS_TS - 1 - i));
      return s[7:0];
    end else if (i < OFS_PAD) begin
      t = ts >> (8 * (OFS_PAD - 1 - i));
      return t[7:0];
    end
    return idx[7:0];
  endfunction

endpackage

// File: rtl/eth_test_gap_cnt.sv
// Loadable down-counter that times the inter-frame gap.
// Ports:
//   clk, srst_n     clock, synchronous active-low reset
//   load, load_val  load the gap length (takes priority over en)
//   en              count down one step per cycle while in the gap
//   done            the current cycle is the last gap cycle
module eth_test_gap_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!srst_n)                     cnt_q <= '0;
    else if (load)                   cnt_q <= load_val;
    else if (en && (cnt_q != '0))    cnt_q <= cnt_q - W'(1);
  end

  // The counter is loaded with N > 0 and done fires while it holds 1.
  // This gives exactly N gap cycles.
  assign done = (cnt_q <= W'(1));

endmodule

// File: rtl/eth_test_frame_gen.sv
// Delay-test Ethernet frame generator.
// Streams DA..padding byte-wise into the MAC TX Avalon-ST sink; the MAC adds
// the preamble and the FCS.
// Each frame carries a sequence number and the value of timestamp_i taken on
// the cycle its first byte is first presented.
// Ports:
//   clk_125m_i, srst_n_i    MAC TX clock, synchronous active-low reset
//   start_i, stop_i         burst control pulses
//   frame_cnt_i (0 = run continuously), frame_len_i, gap_i
//                           burst configuration, latched at start
//   timestamp_i             free-running time counter
//   busy_o, sent_cnt_o      burst status
//   tx_*                    Avalon-ST source (data/valid/sop/eop, ready in)
module eth_test_frame_gen
  import eth_test_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          MIN_LEN   = DEF_MIN_LEN,
  parameter int          MAX_LEN   = DEF_MAX_LEN
) (
  input  logic        clk_125m_i,
  input  logic        srst_n_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] frame_cnt_i,
  input  logic [10:0] frame_len_i,
  input  logic [15:0] gap_i,
  input  logic [63:0] timestamp_i,
  output logic        busy_o,
  output logic [31:0] sent_cnt_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_sop_o,
  output logic        tx_eop_o
);

  localparam logic [10:0]  LEN_LO = 11'(MIN_LEN);
  localparam logic [10:0]  LEN_HI = 11'(MAX_LEN);
  localparam logic [111:0] HDR    = {DST_MAC, SRC_MAC, ETHERTYPE};

  state_t      state_q, state_d;
  logic [31:0] cnt_q, seq_q, sent_q;
  logic [15:0] gap_q;
  logic [10:0] len_q, idx_q, len_clamp;
  logic [63:0] ts_q;
  logic        stop_q, ts_pend_q;
  logic        xfer, last, eop_xfer, burst_done, stop_any, gap_done, gap_load;

  assign len_clamp  = (frame_len_i < LEN_LO) ? LEN_LO :
                      (frame_len_i > LEN_HI) ? LEN_HI : frame_len_i;
  assign xfer       = tx_valid_o & tx_ready_i;
  assign last       = (idx_q == len_q - 11'd1);
  assign eop_xfer   = xfer & last;
  // The frame now completing is the frame_cnt-th frame of the burst.
  assign burst_done = (cnt_q != '0) && (({1'b0, sent_q} + 33'd1) == {1'b0, cnt_q});
  // A stop pulse that lands on the deciding cycle counts as pending.
  assign stop_any   = stop_q | stop_i;
  assign gap_load   = eop_xfer & (state_d == ST_GAP);

  eth_test_gap_cnt #(.W(16)) u_gap (
    .clk      (clk_125m_i),
    .srst_n   (srst_n_i),
    .load     (gap_load),
    .load_val (gap_q),
    .en       (state_q == ST_GAP),
    .done     (gap_done)
  );

  // State register
  always_ff @(posedge clk_125m_i) begin
    if (!srst_n_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_FRAME;
      ST_FRAME: if (eop_xfer) begin
                  if (burst_done || stop_any) state_d = ST_IDLE;
                  else if (gap_q != '0)       state_d = ST_GAP;
                  else                        state_d = ST_FRAME;
                end
      ST_GAP:   if (gap_done) state_d = stop_any ? ST_IDLE : ST_FRAME;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: data, sop and eop are functions of registered state only, so
  // they hold while the sink stalls.
  always_comb begin
    tx_valid_o = (state_q == ST_FRAME);
    busy_o     = (state_q != ST_IDLE);
    tx_data_o  = tx_valid_o ? byte_at(idx_q, seq_q, ts_q, HDR) : 8'h00;
    tx_sop_o   = tx_valid_o && (idx_q == 11'd0);
    tx_eop_o   = tx_valid_o && last;
  end

  assign sent_cnt_o = sent_q;

  // Burst configuration, counters and timestamp capture
  always_ff @(posedge clk_125m_i) begin
    if (!srst_n_i) begin
      cnt_q     <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      sent_q    <= '0;
      ts_q      <= '0;
      stop_q    <= 1'b0;
      ts_pend_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start_i) begin
        cnt_q  <= frame_cnt_i;
        gap_q  <= gap_i;
        len_q  <= len_clamp;
        idx_q  <= '0;
        seq_q  <= '0;
        sent_q <= '0;
      end else if (eop_xfer) begin
        idx_q  <= '0;
        seq_q  <= seq_q + 32'd1;
        if (sent_q != '1) sent_q <= sent_q + 32'd1;
      end else if (xfer) begin
        idx_q  <= idx_q + 11'd1;
      end

      stop_q <= (state_d == ST_IDLE) ? 1'b0 : (stop_q | stop_i);

      // ts_pend marks the first presented cycle of each frame. Back-to-back
      // frames also start a new frame, although the state stays FRAME.
      if ((state_d == ST_FRAME) && ((state_q != ST_FRAME) || eop_xfer))
        ts_pend_q <= 1'b1;
      else if (state_q == ST_FRAME)
        ts_pend_q <= 1'b0;

      if (state_q == ST_FRAME && ts_pend_q) ts_q <= timestamp_i;
    end
  end

endmodule

// File: tb/tb_eth_test_frame_gen.sv
module tb_eth_test_frame_gen;

  logic        clk = 1'b0;
  logic        srst_n;
  logic        start, stop;
  logic [31:0] frame_cnt;
  logic [10:0] frame_len;
  logic [15:0] gap;
  logic [63:0] tstamp = 64'h0102_0304_0506_0000;
  logic        busy;
  logic [31:0] sent;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sop, tx_eop;

  int ncmp = 0;
  int nerr = 0;

  eth_test_frame_gen dut (
    .clk_125m_i  (clk),
    .srst_n_i    (srst_n),
    .start_i     (start),
    .stop_i      (stop),
    .frame_cnt_i (frame_cnt),
    .frame_len_i (frame_len),
    .gap_i       (gap),
    .timestamp_i (tstamp),
    .busy_o      (busy),
    .sent_cnt_o  (sent),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .tx_sop_o    (tx_sop),
    .tx_eop_o    (tx_eop)
  );

  always #4 clk = ~clk;
  always @(posedge clk) tstamp <= tstamp + 64'd1;

  // Independent frame model: fixed header, big-endian seq and ts, index pad.
  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] s,
                                          input logic [63:0] t);
    logic [47:0] sa;
    sa = 48'h0200_0000_0001;
    if (i < 6)        return 8'hFF;
    else if (i < 12)  return sa[47 - 8*(i-6) -: 8];
    else if (i == 12) return 8'h88;
    else if (i == 13) return 8'hB5;
    else if (i < 18)  return s[31 - 8*(i-14) -: 8];
    else if (i < 26)  return t[63 - 8*(i-18) -: 8];
    return 8'(i);
  endfunction

  task automatic pulse_start(input bit with_stop);
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Receives one frame starting at the next falling edge, counting the idle
  // cycles before its sop. Optionally applies random backpressure and pulses
  // stop_i while byte stop_at is presented.
  task automatic recv_frame(input int exp_len, input logic [31:0] exp_seq,
                            input bit rnd, input int stop_at, output int idle);
    logic [63:0] ts_exp;
    logic [9:0]  held;
    int          idx, cyc;
    bit          stall, stop_done;
    idle = 0; idx = 0; cyc = 0; stall = 0; stop_done = 0; held = '0;
    @(negedge clk);
    while (!tx_valid && idle < 5000) begin
      idle++;
      @(negedge clk);
    end
    if (!tx_valid) begin
      ncmp++; nerr++;
      $display("FAIL sop_timeout: valid=0 after %0d cycles, required 1 (seq %0d)", idle, exp_seq);
      return;
    end
    ts_exp = tstamp;
    while (cyc < 20000) begin
      ncmp++;
      if (tx_valid !== 1'b1) begin
        nerr++;
        $display("FAIL valid_drop: seq %0d idx %0d valid=%b, required 1", exp_seq, idx, tx_valid);
        return;
      end
      ncmp++;
      if (tx_data !== exp_byte(idx, exp_seq, ts_exp) || tx_sop !== (idx == 0) ||
          tx_eop !== (idx == exp_len - 1)) begin
        nerr++;
        if (nerr < 40)
          $display("FAIL frame_byte: seq %0d idx %0d got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                   exp_seq, idx, tx_data, tx_sop, tx_eop, exp_byte(idx, exp_seq, ts_exp),
                   idx == 0, idx == exp_len - 1);
      end
      if (stall) begin
        ncmp++;
        if ({tx_data, tx_sop, tx_eop} !== held) begin
          nerr++;
          if (nerr < 40)
            $display("FAIL stall_hold: seq %0d idx %0d got %h, required %h",
                     exp_seq, idx, {tx_data, tx_sop, tx_eop}, held);
        end
      end
      held = {tx_data, tx_sop, tx_eop};
      stop = 1'b0;
      if (idx == stop_at && !stop_done) begin
        stop = 1'b1;
        stop_done = 1;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = !tx_ready;
      if (tx_ready) begin
        if (idx == exp_len - 1) return;
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    ncmp++; nerr++;
    $display("FAIL eop_timeout: seq %0d stuck at idx %0d, required eop at %0d", exp_seq, idx, exp_len - 1);
  endtask

  task automatic test_reset();
    srst_n = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b, required 0", tx_valid); end
    ncmp++; if (tx_sop   !== 1'b0) begin nerr++; $display("FAIL rst_sop: got %b, required 0", tx_sop); end
    ncmp++; if (tx_eop   !== 1'b0) begin nerr++; $display("FAIL rst_eop: got %b, required 0", tx_eop); end
    ncmp++; if (tx_data  !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h, required 00", tx_data); end
    ncmp++; if (busy     !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b, required 0", busy); end
    ncmp++; if (sent     !== 32'd0) begin nerr++; $display("FAIL rst_sent: got %0d, required 0", sent); end
    srst_n = 1'b1;
    stop = 1'b1;                                   // a stop in IDLE is ignored
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic();
    int idle;
    frame_cnt = 32'd3; frame_len = 11'd64; gap = 16'd12; tx_ready = 1'b1;
    @(negedge clk);
    pulse_start(0);
    for (int f = 0; f < 3; f++) begin
      recv_frame(64, 32'(f), 0, -1, idle);
      ncmp++;
      if (idle != ((f == 0) ? 0 : 12)) begin
        nerr++; $display("FAIL basic_gap: frame %0d idle=%0d, required %0d", f, idle, (f == 0) ? 0 : 12);
      end
    end
    @(negedge clk);
    ncmp++; if (sent !== 32'd3) begin nerr++; $display("FAIL basic_sent: got %0d, required 3", sent); end
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_busy: got %b, required 0", busy); end
    repeat (20) @(negedge clk);
    ncmp++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL basic_extra: valid=%b, required 0", tx_valid); end
  endtask

  task automatic test_len_clamp();
    int idle;
    logic [10:0] req [2];
    int          got [2];
    req[0] = 11'd20;   got[0] = 60;
    req[1] = 11'd2000; got[1] = 1514;
    for (int k = 0; k < 2; k++) begin
      frame_cnt = 32'd1; frame_len = req[k]; gap = 16'd0; tx_ready = 1'b1;
      @(negedge clk);
      pulse_start(0);
      ncmp++; if (sent !== 32'd0) begin nerr++; $display("FAIL clamp_sent_clr: got %0d, required 0", sent); end
      recv_frame(got[k], 32'd0, 0, -1, idle);
      @(negedge clk);
      ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL clamp_busy: len %0d busy=%b, required 0", got[k], busy); end
      ncmp++; if (sent !== 32'd1) begin nerr++; $display("FAIL clamp_sent: got %0d, required 1", sent); end
    end
  endtask

  task automatic test_backpressure();
    int idle;
    frame_cnt = 32'd2; frame_len = 11'd80; gap = 16'd3; tx_ready = 1'b1;
    @(negedge clk);
    pulse_start(0);
    for (int f = 0; f < 2; f++) begin
      recv_frame(80, 32'(f), 1, -1, idle);
      if (f == 1) begin
        ncmp++; if (idle != 3) begin nerr++; $display("FAIL bp_gap: idle=%0d, required 3", idle); end
      end
    end
    tx_ready = 1'b1;
    @(negedge clk);
    ncmp++; if (sent !== 32'd2) begin nerr++; $display("FAIL bp_sent: got %0d, required 2", sent); end
  endtask

  task automatic test_stop();
    int idle;
    frame_cnt = 32'd0; frame_len = 11'd60; gap = 16'd0; tx_ready = 1'b1;
    @(negedge clk);
    pulse_start(0);
    for (int f = 0; f < 6; f++) begin
      recv_frame(60, 32'(f), 0, (f == 5) ? 10 : -1, idle);
      if (f > 0) begin
        ncmp++; if (idle != 0) begin nerr++; $display("FAIL stop_b2b: frame %0d idle=%0d, required 0", f, idle); end
      end
    end
    @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL stop_busy: got %b, required 0", busy); end
    ncmp++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL stop_valid: got %b, required 0", tx_valid); end
    ncmp++; if (sent !== 32'd6) begin nerr++; $display("FAIL stop_sent: got %0d, required 6", sent); end
  endtask

  task automatic test_start_stop();
    int idle;
    frame_cnt = 32'd0; frame_len = 11'd60; gap = 16'd5; tx_ready = 1'b1;
    @(negedge clk);
    pulse_start(1);
    recv_frame(60, 32'd0, 0, -1, idle);
    @(negedge clk);
    ncmp++; if (busy !== 1'b0) begin nerr++; $display("FAIL ss_busy: got %b, required 0", busy); end
    ncmp++; if (sent !== 32'd1) begin nerr++; $display("FAIL ss_sent: got %0d, required 1", sent); end
  endtask

  task automatic test_reset_mid();
    int idle;
    frame_cnt = 32'd0; frame_len = 11'd64; gap = 16'd0; tx_ready = 1'b1;
    @(negedge clk);
    pulse_start(0);
    recv_frame(64, 32'd0, 0, -1, idle);
    repeat (31) @(negedge clk);                    // byte 30 of the second frame
    ncmp++;
    if (tx_valid !== 1'b1 || tx_data !== 8'd30) begin
      nerr++; $display("FAIL rm_byte30: valid=%b data=%h, required 1/1e", tx_valid, tx_data);
    end
    srst_n = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({tx_valid, tx_sop, tx_eop, busy} !== 4'b0 || tx_data !== 8'h00 || sent !== 32'd0) begin
      nerr++; $display("FAIL rm_outputs: valid=%b sop=%b eop=%b busy=%b data=%h sent=%0d, required all 0",
                       tx_valid, tx_sop, tx_eop, busy, tx_data, sent);
    end
    srst_n = 1'b1;
    frame_cnt = 32'd1;
    @(negedge clk);
    pulse_start(0);
    recv_frame(64, 32'd0, 0, -1, idle);
    @(negedge clk);
    ncmp++; if (sent !== 32'd1) begin nerr++; $display("FAIL rm_sent: got %0d, required 1", sent); end
  endtask

  initial begin
    srst_n = 1'b0; start = 1'b0; stop = 1'b0; tx_ready = 1'b1;
    frame_cnt = '0; frame_len = '0; gap = '0;
    test_reset();
    test_basic();
    test_len_clamp();
    test_backpressure();
    test_stop();
    test_start_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
